// File: rtl/conv_layer_sequencer_pkg.sv
// conv_layer_sequencer_pkg: shared FSM state type, index width and output-size helper for conv sequencing
package conv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} seq_state_t;
  localparam int IDX_W = 16;
  function automatic int out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction
endpackage

// File: rtl/conv_layer_sequencer_if.sv
// conv_layer_sequencer_if: activation source, conv_layer write/result ports and result echo bundle
interface conv_layer_sequencer_if #(
  parameter int DATA_SIZE = 64,
  parameter int IDX_W = conv_pkg::IDX_W
);
  logic src_valid;
  logic src_ready;
  logic [DATA_SIZE-1:0] src_data;
  logic conv_want_write;
  logic [DATA_SIZE-1:0] conv_write_data;
  logic [2:0][IDX_W-1:0] conv_in_index;
  logic conv_out_valid;
  logic [DATA_SIZE-1:0] conv_out_data;
  logic [2:0][IDX_W-1:0] conv_out_index;
  logic res_valid;
  logic [DATA_SIZE-1:0] res_data;
  logic [2:0][IDX_W-1:0] res_index;
  modport master (
    input src_valid, src_data, conv_out_valid, conv_out_data, conv_out_index,
    output src_ready, conv_want_write, conv_write_data, conv_in_index, res_valid, res_data, res_index
  );
  modport slave (
    output src_valid, src_data, conv_out_valid, conv_out_data, conv_out_index,
    input src_ready, conv_want_write, conv_write_data, conv_in_index, res_valid, res_data, res_index
  );
endinterface

// File: rtl/conv_layer_sequencer_idx_counter.sv
// conv_idx_counter: raster-order col/row/ch counter with clear, increment and last-position flag
module conv_idx_counter #(
  parameter int NUM_INPUTS = 1,
  parameter int INPUT_DIM = 28,
  parameter int IDX_W = conv_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [IDX_W-1:0] ch,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  logic [IDX_W-1:0] ch_q, ch_d, row_q, row_d, col_q, col_d;
  logic col_end, row_end, ch_end;
  // Wrap col into row into ch; clear wins over increment
  always_comb begin
    col_end = col_q == IDX_W'(INPUT_DIM - 1);
    row_end = row_q == IDX_W'(INPUT_DIM - 1);
    ch_end = ch_q == IDX_W'(NUM_INPUTS - 1);
    col_d = clr ? '0 : inc ? (col_end ? '0 : col_q + IDX_W'(1)) : col_q;
    row_d = clr ? '0 : (inc & col_end) ? (row_end ? '0 : row_q + IDX_W'(1)) : row_q;
    ch_d = clr ? '0 : (inc & col_end & row_end) ? (ch_end ? '0 : ch_q + IDX_W'(1)) : ch_q;
    last = ch_end & row_end & col_end;
  end
  // Index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      ch_q <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign ch = ch_q;
  assign row = row_q;
  assign col = col_q;
endmodule

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: streams one layer's activations into conv_layer and counts its results to done
module conv_layer_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int NUM_INPUTS = 1,
  parameter int INPUT_DIM = 28,
  parameter int NUM_OUTPUTS = 16,
  parameter int KERNEL_DIM = 3,
  parameter int IDX_W = conv_pkg::IDX_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  conv_layer_sequencer_if.master bus,
  output logic busy,
  output logic done,
  output logic err_extra
);
  localparam int OUT_DIM = out_dim(INPUT_DIM, KERNEL_DIM);
  localparam int EXPECTED = NUM_OUTPUTS * OUT_DIM * OUT_DIM;
  localparam int CNT_W = $clog2(EXPECTED + 1);
  seq_state_t state_q, state_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [IDX_W-1:0] ch, row, col;
  logic last, src_ready, xfer, idx_clr, cnt_full, fin;
  logic want_q, want_d, res_valid_q, res_valid_d, done_q, done_d, err_q, err_d;
  logic [DATA_SIZE-1:0] wdata_q, wdata_d, res_data_q, res_data_d;
  logic [2:0][IDX_W-1:0] widx_q, widx_d, res_idx_q, res_idx_d;

  conv_idx_counter #(
    .NUM_INPUTS(NUM_INPUTS),
    .INPUT_DIM(INPUT_DIM),
    .IDX_W(IDX_W)
  ) u_idx (
    .clk(clk),
    .rst_n(rst_n),
    .clr(idx_clr),
    .inc(xfer),
    .ch(ch),
    .row(row),
    .col(col),
    .last(last)
  );

  // Handshake and result counting; a counter saturated at EXPECTED stops counting
  always_comb begin
    src_ready = (state_q == LOAD) & ~abort;
    xfer = bus.src_valid & src_ready;
    idx_clr = abort | ((state_q == IDLE) & start);
    cnt_full = out_cnt_q == CNT_W'(EXPECTED);
    out_cnt_d = idx_clr ? '0 : (state_q != IDLE & bus.conv_out_valid & ~cnt_full) ? out_cnt_q + CNT_W'(1) : out_cnt_q;
    fin = out_cnt_d == CNT_W'(EXPECTED);
  end

  // Next state: abort dominates; loading ends on the last accepted activation
  always_comb begin
    state_d = state_q;
    if (abort) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = start ? LOAD : IDLE;
        LOAD: state_d = (xfer & last) ? (fin ? IDLE : DRAIN) : LOAD;
        DRAIN: state_d = fin ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
  end

  // Outputs: write strobe, result echo, completion and sticky overflow flag
  always_comb begin
    busy = state_q != IDLE;
    done_d = fin & ((state_q == DRAIN) | ((state_q == LOAD) & xfer & last));
    want_d = xfer;
    wdata_d = xfer ? bus.src_data : wdata_q;
    widx_d = xfer ? {ch, row, col} : widx_q;
    res_valid_d = bus.conv_out_valid;
    res_data_d = bus.conv_out_valid ? bus.conv_out_data : res_data_q;
    res_idx_d = bus.conv_out_valid ? bus.conv_out_index : res_idx_q;
    err_d = err_q | (bus.conv_out_valid & ((state_q == IDLE) | cnt_full));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Counter and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt_q <= '0;
      want_q <= 1'b0;
      wdata_q <= '0;
      widx_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_idx_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      out_cnt_q <= out_cnt_d;
      want_q <= want_d;
      wdata_q <= wdata_d;
      widx_q <= widx_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_idx_q <= res_idx_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign bus.src_ready = src_ready;
  assign bus.conv_want_write = want_q;
  assign bus.conv_write_data = wdata_q;
  assign bus.conv_in_index = widx_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data = res_data_q;
  assign bus.res_index = res_idx_q;
  assign done = done_q;
  assign err_extra = err_q;
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: directed stimulus against a count-based model of one sequencer pass
module tb_conv_layer_sequencer;
  localparam int DIM = 4;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int K = 3;
  localparam int EXP = NO * (DIM - K + 1) * (DIM - K + 1);
  localparam int TOTAL = NI * DIM * DIM;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, err_extra;
  int n_chk = 0;
  int n_fail = 0;

  conv_layer_sequencer_if #(.DATA_SIZE(64), .IDX_W(16)) bus ();

  conv_layer_sequencer #(
    .DATA_SIZE(64),
    .NUM_INPUTS(NI),
    .INPUT_DIM(DIM),
    .NUM_OUTPUTS(NO),
    .KERNEL_DIM(K),
    .IDX_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .bus(bus),
    .busy(busy),
    .done(done),
    .err_extra(err_extra)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] idx_of(input int n);
    return {16'(n / (DIM * DIM)), 16'((n / DIM) % DIM), 16'(n % DIM)};
  endfunction

  // Model: a pass is "active" until TOTAL loads and EXP results have both been seen
  bit m_active;
  int m_n, m_outs;
  logic e_want, e_resv, e_done, e_err;
  logic [63:0] e_wdata, e_resd;
  logic [47:0] e_widx, e_resi;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_n = 0; m_outs = 0;
      e_want = 0; e_wdata = 0; e_widx = 0;
      e_resv = 0; e_resd = 0; e_resi = 0;
      e_done = 0; e_err = 0;
    end else begin : upd
      bit xf;
      int o_inc;
      xf = bus.src_valid && m_active && m_n < TOTAL && !abort;
      e_want = xf;
      if (xf) begin
        e_wdata = bus.src_data;
        e_widx = idx_of(m_n);
      end
      e_resv = bus.conv_out_valid;
      if (bus.conv_out_valid) begin
        e_resd = bus.conv_out_data;
        e_resi = bus.conv_out_index;
      end
      if (bus.conv_out_valid && (!m_active || m_outs == EXP)) e_err = 1;
      e_done = 0;
      if (abort) begin
        m_active = 0; m_n = 0; m_outs = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_n = 0; m_outs = 0;
        end
      end else begin
        o_inc = (bus.conv_out_valid && m_outs < EXP) ? 1 : 0;
        m_n = m_n + (xf ? 1 : 0);
        m_outs = m_outs + o_inc;
        e_done = (m_n == TOTAL) && (m_outs == EXP);
        if (e_done) m_active = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", busy, m_active);
    chk("src_ready", bus.src_ready, rst_n && m_active && m_n < TOTAL && !abort);
    chk("want_write", bus.conv_want_write, e_want);
    chk("write_data", bus.conv_write_data, e_wdata);
    chk("in_index", bus.conv_in_index, e_widx);
    chk("res_valid", bus.res_valid, e_resv);
    chk("res_data", bus.res_data, e_resd);
    chk("res_index", bus.res_index, e_resi);
    chk("done", done, e_done);
    chk("err_extra", err_extra, e_err);
  end

  logic [47:0] wr_log[$];
  int n_done = 0;
  always @(negedge clk) begin
    if (bus.conv_want_write) wr_log.push_back(bus.conv_in_index);
    if (done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // vmode: 0 no valid, 1 valid held, 2 valid on even cycles; results pulse on [out_start, out_start+out_n)
  task automatic run(input int cycles, input int vmode, input int out_start, input int out_n);
    for (int c = 0; c < cycles; c++) begin
      bus.src_valid = (vmode == 1) || (vmode == 2 && c % 2 == 0);
      bus.src_data = 64'hA000 + 64'(c);
      bus.conv_out_valid = (c >= out_start) && (c < out_start + out_n);
      bus.conv_out_data = 64'hB000 + 64'(c);
      bus.conv_out_index = {16'(c), 16'(c + 1), 16'(c + 2)};
      step();
    end
    bus.src_valid = 1'b0;
    bus.conv_out_valid = 1'b0;
  endtask

  initial begin
    int base_w, base_d;
    bus.src_valid = 0; bus.src_data = 0;
    bus.conv_out_valid = 0; bus.conv_out_data = 0; bus.conv_out_index = 0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_want", bus.conv_want_write, 0);
    chk("rst_index", bus.conv_in_index, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_extra, 0);
    rst_n = 1'b1;
    step();

    base_w = wr_log.size(); base_d = n_done;
    start_pass();
    run(42, 1, 32, 8);
    step();
    chk("t1_writes", wr_log.size() - base_w, 32);
    chk("t1_first_idx", wr_log[base_w], 48'h0);
    chk("t1_last_idx", wr_log[base_w + 31], 48'h0001_0003_0003);
    chk("t1_done_cnt", n_done - base_d, 1);
    chk("t1_busy", busy, 0);

    base_w = wr_log.size(); base_d = n_done;
    start_pass();
    run(74, 2, 64, 8);
    step();
    chk("t2_writes", wr_log.size() - base_w, 32);
    chk("t2_idx5", wr_log[base_w + 5], 48'h0000_0001_0001);
    chk("t2_last_idx", wr_log[base_w + 31], 48'h0001_0003_0003);
    chk("t2_done_cnt", n_done - base_d, 1);

    base_w = wr_log.size(); base_d = n_done;
    start_pass();
    run(10, 1, 0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_abort_idle", busy, 0);
    step();
    chk("t3_writes", wr_log.size() - base_w, 10);
    chk("t3_no_done", n_done - base_d, 0);
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("t3_start_abort", busy, 0);
    base_w = wr_log.size();
    start_pass();
    run(1, 1, 0, 0);
    step();
    chk("t3_restart_cnt", wr_log.size() - base_w, 1);
    chk("t3_restart_idx", wr_log[base_w], 48'h0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    base_d = n_done;
    start_pass();
    run(32, 1, 24, 8);
    chk("t4_done_now", done, 1);
    chk("t4_idle_now", busy, 0);
    step();
    chk("t4_done_cnt", n_done - base_d, 1);

    start_pass();
    run(34, 1, 0, 9);
    chk("t5_ninth_err", err_extra, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_err_cleared", err_extra, 0);
    run(3, 0, 1, 1);
    chk("t5_idle_err", err_extra, 1);
    step();
    chk("t5_err_sticky", err_extra, 1);

    start_pass();
    run(35, 1, 32, 3);
    chk("t6_in_drain", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_err", err_extra, 0);
    chk("t6_rst_resv", bus.res_valid, 0);
    chk("t6_rst_wdata", bus.conv_write_data, 0);
    step();
    rst_n = 1'b1;
    base_d = n_done; base_w = wr_log.size();
    run(10, 1, 0, 0);
    step();
    chk("t6_no_done", n_done - base_d, 0);
    chk("t6_no_write", wr_log.size() - base_w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
